segment_scan4: RTL

Four-digit time-multiplexed display driver that sits directly downstream of the single-digit `segment` encoder. Up to four 7-bit segment patterns are written into digit registers, and the block scans them onto one shared segment bus with one-hot digit enables. An inter-digit blanking interval suppresses ghosting, and a frame-complete pulse is produced once per full scan.

---
 rtl/segment_scan4.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/segment_scan4.sv
// segment_scan4: four-digit time-multiplexed 7-segment scanner with
// inter-digit blanking and a once-per-frame completion pulse.
module segment_scan4 #(
    parameter int unsigned SHOW_CYCLES  = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [6:0] wr_data,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShow  = 2'd1,
        StBlank = 2'd2
    } state_e;

    localparam logic [15:0] ShowLast  = 16'(SHOW_CYCLES - 1);
    // Guarded so a zero blank count does not wrap; unused in that build anyway.
    localparam logic [15:0] BlankLast = (BLANK_CYCLES == 0) ? 16'd0 : 16'(BLANK_CYCLES - 1);
    localparam bit          HasBlank  = (BLANK_CYCLES != 0);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  digit_q [4];
    logic [6:0]  digit_d [4];
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_done_q, frame_done_d;

    // Digit register write port; a write is visible to the output stage in the same edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_d[i] = digit_q[i];
        end
        if (wr_en) begin
            digit_d[wr_addr] = wr_data;
        end
    end

    // Scanner next state: the registered state describes the current output cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StShow;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        cnt_d = 16'd0;
                        if (HasBlank) begin
                            state_d = StBlank;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShow;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Output stage decoded from the next state so outputs line up with it.
    always_comb begin
        seg_d        = 7'd0;
        an_d         = 4'd0;
        frame_done_d = 1'b0;
        if (state_d == StShow) begin
            seg_d = digit_d[idx_d];
            an_d  = 4'b0001 << idx_d;
            if (!HasBlank && idx_d == 2'd3 && cnt_d == ShowLast) begin
                frame_done_d = 1'b1;
            end
        end
        if (state_d == StBlank && idx_d == 2'd3 && cnt_d == BlankLast) begin
            frame_done_d = 1'b1;
        end
    end

    // State, storage and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= 2'd0;
            cnt_q        <= 16'd0;
            seg_q        <= 7'd0;
            an_q         <= 4'd0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 7'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
